ps2_player_input: RTL and testbench

- Decodes raw PS/2 keyboard traffic (scan code set 2) into held-key movement levels and one-cycle bomb pulses for both players.
- Drives the p1_/p2_ bomb, xdir, xmov, ydir and ymov inputs of the game datapath.
- P1 keys: W/A/S/D and Space. P2 keys: the four arrow keys (E0-prefixed) and Enter.

---
 rtl/ps2_player_input_if.sv | 33 +++
 rtl/ps2_player_input.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_player_input.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_player_input_if.sv
// Bundle of the raw PS/2 lines and the decoded player controls.
// slave is the decoder's view; master is the keyboard/game-side view.
interface ps2_player_input_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       p1_bomb;
  logic       p1_xdir;
  logic       p1_xmov;
  logic       p1_ydir;
  logic       p1_ymov;
  logic       p2_bomb;
  logic       p2_xdir;
  logic       p2_xmov;
  logic       p2_ydir;
  logic       p2_ymov;
  logic [7:0] scan_byte;
  logic       byte_valid;
  logic       rx_error;

  modport master (
    output ps2_clk, ps2_dat,
    input  p1_bomb, p1_xdir, p1_xmov, p1_ydir, p1_ymov,
    input  p2_bomb, p2_xdir, p2_xmov, p2_ydir, p2_ymov,
    input  scan_byte, byte_valid, rx_error
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output p1_bomb, p1_xdir, p1_xmov, p1_ydir, p1_ymov,
    output p2_bomb, p2_xdir, p2_xmov, p2_ydir, p2_ymov,
    output scan_byte, byte_valid, rx_error
  );
endinterface

// File: rtl/ps2_player_input.sv
// PS/2 scan-set-2 receiver that turns key make/break traffic into held-key
// movement levels and one-cycle bomb pulses for two players.
module ps2_player_input #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input logic               clock,
  input logic               reset,
  ps2_player_input_if.slave bus
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  typedef enum logic [3:0] {
    K_P1_UP, K_P1_DOWN, K_P1_LEFT, K_P1_RIGHT, K_P1_BOMB,
    K_P2_UP, K_P2_DOWN, K_P2_LEFT, K_P2_RIGHT, K_P2_BOMB
  } key_e;
  localparam int NUM_KEYS = 10;

  typedef struct packed {
    logic hit;
    key_e key;
  } key_lookup_t;

  function automatic key_lookup_t lookup(input logic ext, input logic [7:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.key = K_P1_UP;
    case ({ext, code})
      9'h01D:  r.key = K_P1_UP;
      9'h01B:  r.key = K_P1_DOWN;
      9'h01C:  r.key = K_P1_LEFT;
      9'h023:  r.key = K_P1_RIGHT;
      9'h029:  r.key = K_P1_BOMB;
      9'h175:  r.key = K_P2_UP;
      9'h172:  r.key = K_P2_DOWN;
      9'h16B:  r.key = K_P2_LEFT;
      9'h174:  r.key = K_P2_RIGHT;
      9'h05A:  r.key = K_P2_BOMB;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- sync
  logic [SS-1:0] clk_sync, dat_sync;
  logic          clk_prev;
  logic          clk_s, dat_s, fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      // NOTE: clocked state uses <= so every flop samples pre-edge values;
      // blocking = here would collapse the synchroniser chain into one stage.
      clk_sync <= {clk_sync[SS-2:0], bus.ps2_clk};
      dat_sync <= {dat_sync[SS-2:0], bus.ps2_dat};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SS-1];
  assign dat_s = dat_sync[SS-1];
  assign fall  = clk_prev & ~clk_s;

  // ---------------------------------------------------------- frame FSM
  state_e        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tmo_cnt;
  logic          accept, bad, abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      tmo_cnt <= (fall || state == IDLE) ? '0 : tmo_cnt + TMO_ONE;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    accept    = 1'b0;
    bad       = 1'b0;
    abort     = 1'b0;

    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n[bit_cnt] = dat_s;
          if (bit_cnt == 3'd7) state_n = PARITY;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
        PARITY: begin
          par_n   = dat_s;
          state_n = STOP;
        end
        STOP: begin
          if (dat_s && ^{shift, par}) accept = 1'b1;
          else                        bad    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_n = IDLE;
      abort   = 1'b1;
    end
  end

  // Frame events are staged one cycle so decode and outputs land together.
  logic [7:0] rx_byte;
  logic       byte_ready, err_pend, clr_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_byte    <= '0;
      byte_ready <= 1'b0;
      err_pend   <= 1'b0;
      clr_pend   <= 1'b0;
    end else begin
      if (accept) rx_byte <= shift;
      byte_ready <= accept;
      err_pend   <= bad;
      clr_pend   <= bad | abort;
    end
  end

  // -------------------------------------------------------------- decode
  logic [NUM_KEYS-1:0] held, held_n;
  logic                brk, brk_n, ext, ext_n;
  logic                bomb1_n, bomb2_n;
  key_lookup_t         lk;

  always_comb begin
    held_n  = held;
    brk_n   = brk;
    ext_n   = ext;
    bomb1_n = 1'b0;
    bomb2_n = 1'b0;
    lk      = lookup(ext, rx_byte);

    if (clr_pend) begin
      brk_n = 1'b0;
      ext_n = 1'b0;
    end else if (byte_ready) begin
      if (rx_byte == 8'hF0) begin
        brk_n = 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext_n = 1'b1;
      end else begin
        if (lk.hit) begin
          held_n[lk.key] = !brk;
          // Only a fresh make fires a bomb; typematic repeats find it held.
          if (!brk && !held[lk.key]) begin
            bomb1_n = (lk.key == K_P1_BOMB);
            bomb2_n = (lk.key == K_P2_BOMB);
          end
        end
        brk_n = 1'b0;
        ext_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held           <= '0;
      brk            <= 1'b0;
      ext            <= 1'b0;
      bus.p1_bomb    <= 1'b0;
      bus.p1_xdir    <= 1'b0;
      bus.p1_xmov    <= 1'b0;
      bus.p1_ydir    <= 1'b0;
      bus.p1_ymov    <= 1'b0;
      bus.p2_bomb    <= 1'b0;
      bus.p2_xdir    <= 1'b0;
      bus.p2_xmov    <= 1'b0;
      bus.p2_ydir    <= 1'b0;
      bus.p2_ymov    <= 1'b0;
      bus.scan_byte  <= '0;
      bus.byte_valid <= 1'b0;
      bus.rx_error   <= 1'b0;
    end else begin
      held           <= held_n;
      brk            <= brk_n;
      ext            <= ext_n;
      bus.p1_bomb    <= bomb1_n;
      bus.p1_xdir    <= held_n[K_P1_RIGHT];
      bus.p1_xmov    <= held_n[K_P1_LEFT] ^ held_n[K_P1_RIGHT];
      bus.p1_ydir    <= held_n[K_P1_DOWN];
      bus.p1_ymov    <= held_n[K_P1_UP] ^ held_n[K_P1_DOWN];
      bus.p2_bomb    <= bomb2_n;
      bus.p2_xdir    <= held_n[K_P2_RIGHT];
      bus.p2_xmov    <= held_n[K_P2_LEFT] ^ held_n[K_P2_RIGHT];
      bus.p2_ydir    <= held_n[K_P2_DOWN];
      bus.p2_ymov    <= held_n[K_P2_UP] ^ held_n[K_P2_DOWN];
      if (byte_ready) bus.scan_byte <= rx_byte;
      bus.byte_valid <= byte_ready;
      bus.rx_error   <= err_pend;
    end
  end

endmodule

// File: tb/tb_ps2_player_input.sv
// Directed bench: bit-bangs PS/2 frames and checks decoded player controls.
module tb_ps2_player_input;

  localparam int TMO = 400;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps2_player_input_if bus();

  ps2_player_input #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0, fall_cyc = 0, bv_cyc = 0;
  int bv_cnt = 0, b1_cnt = 0, b2_cnt = 0, err_cnt = 0;
  int bv0, b10, b20, err0;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters: each counts high cycles, so a one-cycle pulse adds 1.
  always @(negedge clock) begin
    if (bus.byte_valid) begin bv_cnt++; bv_cyc = cyc; end
    if (bus.p1_bomb)  b1_cnt++;
    if (bus.p2_bomb)  b2_cnt++;
    if (bus.rx_error) err_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] p1v();
    return {bus.p1_xdir, bus.p1_xmov, bus.p1_ydir, bus.p1_ymov};
  endfunction

  function automatic logic [3:0] p2v();
    return {bus.p2_xdir, bus.p2_xmov, bus.p2_ydir, bus.p2_ymov};
  endfunction

  task automatic snap();
    bv0 = bv_cnt; b10 = b1_cnt; b20 = b2_cnt; err0 = err_cnt;
  endtask

  task automatic clk_bit(input logic d, input bit mark);
    @(negedge clock);
    bus.ps2_dat = d;
    repeat (5) @(negedge clock);
    bus.ps2_clk = 1'b0;
    if (mark) fall_cyc = cyc;
    repeat (10) @(negedge clock);
    bus.ps2_clk = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    clk_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) clk_bit(b[i], 0);
    clk_bit(p, 0);
    clk_bit(!bad_stop, 1);
    bus.ps2_dat = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    clk_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) clk_bit(b[i], 0);
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_p1", p1v(), 4'b0000);
    check("reset_p2", p2v(), 4'b0000);
    check("reset_scan", bus.scan_byte, 8'h00);
    check("reset_bv", bus.byte_valid, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // D make: +X movement, one byte_valid, fixed latency
    snap();
    send_frame(8'h23);
    check("d_make_p1", p1v(), 4'b1100);
    check("d_make_scan", bus.scan_byte, 8'h23);
    check("d_make_bv_pulse", bv_cnt - bv0, 1);
    check("latency", bv_cyc - fall_cyc, 4);

    send_frame(8'hF0); send_frame(8'h23);
    check("d_break_p1", p1v(), 4'b0000);

    // Arrow up (extended), release, then non-extended 75 and extended 1D
    send_frame(8'hE0); send_frame(8'h75);
    check("up_make_p2", p2v(), 4'b0001);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check("up_break_p2", p2v(), 4'b0000);
    send_frame(8'h75);
    check("plain75_p2", p2v(), 4'b0000);
    check("plain75_scan", bus.scan_byte, 8'h75);
    send_frame(8'hE0); send_frame(8'h1D);
    check("ext1d_p1", p1v(), 4'b0000);

    // Space typematic: single pulse; break re-arms
    snap();
    send_frame(8'h29); send_frame(8'h29); send_frame(8'h29);
    check("space_x3_bomb", b1_cnt - b10, 1);
    send_frame(8'hF0); send_frame(8'h29); send_frame(8'h29);
    check("space_rearm_bomb", b1_cnt - b10, 2);
    send_frame(8'h5A);
    check("enter_bomb2", b2_cnt - b20, 1);
    check("enter_no_bomb1", b1_cnt - b10, 2);

    // A and D both held, then release A
    send_frame(8'h1C); send_frame(8'h23);
    check("ad_both_p1", p1v(), 4'b1000);
    send_frame(8'hF0); send_frame(8'h1C);
    check("a_release_p1", p1v(), 4'b1100);
    send_frame(8'hF0); send_frame(8'h23);
    check("d_release_p1", p1v(), 4'b0000);

    // Receive errors; the preceding F0 must be dropped by the error
    send_frame(8'hF0);
    snap();
    send_frame(8'h1D, 1, 0);
    check("badpar_err", err_cnt - err0, 1);
    check("badpar_bv", bv_cnt - bv0, 0);
    check("badpar_p1", p1v(), 4'b0000);
    snap();
    send_frame(8'h1D, 0, 1);
    check("badstop_err", err_cnt - err0, 1);
    check("badstop_bv", bv_cnt - bv0, 0);
    send_frame(8'h1D);
    check("w_after_err_p1", p1v(), 4'b0001);
    send_frame(8'hF0); send_frame(8'h1D);
    check("w_release_p1", p1v(), 4'b0000);

    // Timeout mid-frame also drops a pending F0, without rx_error
    send_frame(8'hF0);
    snap();
    send_partial(8'h1C, 4);
    bus.ps2_dat = 1'b1;
    repeat (TMO + 50) @(negedge clock);
    check("tmo_no_err", err_cnt - err0, 0);
    check("tmo_no_bv", bv_cnt - bv0, 0);
    send_frame(8'h1C);
    check("a_after_tmo_p1", p1v(), 4'b0100);
    check("a_after_tmo_scan", bus.scan_byte, 8'h1C);

    // Asynchronous reset mid-frame clears outputs immediately
    send_partial(8'h23, 3);
    #3 reset = 1'b1;
    #1;
    check("midreset_p1", p1v(), 4'b0000);
    check("midreset_scan", bus.scan_byte, 8'h00);
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    send_frame(8'h23);
    check("d_after_reset_p1", p1v(), 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
